// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage: PC, single-entry instruction buffer,
// ROM-style memory handshake and branch redirect with misalignment trap.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        iClk,
    input  logic        iRst,
    output logic        oIMem_Req,
    output logic [31:0] oIMem_Addr,
    input  logic        iIMem_Ready,
    input  logic [31:0] iIMem_Rdata,
    output logic [31:0] oInst_Code,
    output logic [31:0] oInst_PC,
    output logic        oInst_Valid,
    input  logic        iInst_Ready,
    input  logic        iRedirect,
    input  logic [31:0] iRedirect_PC,
    output logic        oFetch_Err
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] code_q, code_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            code_q  <= NOP_INST;
            ipc_q   <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        code_d  = code_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        err_d   = err_q;
        // Redirect wins over both handshakes; a misaligned target traps.
        if (state_q != S_ERR && iRedirect) begin
            valid_d = 1'b0;
            code_d  = NOP_INST;
            if (iRedirect_PC[1:0] == 2'b00) begin
                pc_d    = iRedirect_PC;
                state_d = S_FETCH;
            end else begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (iIMem_Ready) begin
                        code_d  = iIMem_Rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (iInst_Ready) begin
                        valid_d = 1'b0;
                        code_d  = NOP_INST;
                        state_d = S_FETCH;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign oIMem_Req   = (state_q == S_FETCH) && !iRst;
    assign oIMem_Addr  = pc_q;
    assign oInst_Code  = code_q;
    assign oInst_PC    = ipc_q;
    assign oInst_Valid = valid_q;
    assign oFetch_Err  = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: ROM model, stall/hold/redirect/trap
// scenarios, and a second instance exercising PC wrap and mid-fetch reset.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, mem_rdy, iready, redir;
    logic [31:0] redir_pc;
    logic        req, valid, err;
    logic [31:0] addr, rdata, code, ipc;

    logic        rst2, rdy2, iready2, redir2;
    logic [31:0] redir_pc2;
    logic        req2, valid2, err2;
    logic [31:0] addr2, rdata2, code2, ipc2;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 32'h0050_0093;
            32'h4:   rom = 32'h00A0_0113;
            default: rom = a ^ 32'h1234_5678;
        endcase
    endfunction

    assign rdata  = rom(addr);
    assign rdata2 = rom(addr2);

    inst_fetch dut (
        .iClk(clk), .iRst(rst),
        .oIMem_Req(req), .oIMem_Addr(addr),
        .iIMem_Ready(mem_rdy), .iIMem_Rdata(rdata),
        .oInst_Code(code), .oInst_PC(ipc), .oInst_Valid(valid),
        .iInst_Ready(iready),
        .iRedirect(redir), .iRedirect_PC(redir_pc),
        .oFetch_Err(err)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .iClk(clk), .iRst(rst2),
        .oIMem_Req(req2), .oIMem_Addr(addr2),
        .iIMem_Ready(rdy2), .iIMem_Rdata(rdata2),
        .oInst_Code(code2), .oInst_PC(ipc2), .oInst_Valid(valid2),
        .iInst_Ready(iready2),
        .iRedirect(redir2), .iRedirect_PC(redir_pc2),
        .oFetch_Err(err2)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        sb_q.push_back({pc, rom(pc)});
    endtask

    // Consumption happens at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1 && iready === 1'b1) begin
            if (sb_q.size() == 0)
                check("sb_unexpected", {ipc, code}, 64'h0);
            else
                check("sb_inst", {ipc, code}, sb_q.pop_front());
        end
    end

    initial begin
        logic [31:0] hold_code, hold_pc;
        rst = 1'b1; mem_rdy = 1'b0; iready = 1'b0;
        redir = 1'b0; redir_pc = 32'h0;
        rst2 = 1'b1; rdy2 = 1'b0; iready2 = 1'b1;
        redir2 = 1'b0; redir_pc2 = 32'h0;
        step();
        step();
        check("rst_req", {63'h0, req}, 64'h0);
        check("rst_valid", {63'h0, valid}, 64'h0);
        check("rst_code", {32'h0, code}, {32'h0, NOP});
        check("rst_pc", {32'h0, ipc}, 64'h0);
        check("rst_err", {63'h0, err}, 64'h0);
        rst = 1'b0;
        #1;
        check("first_req", {31'h0, req, addr}, {31'h0, 1'b1, 32'h0});

        // Zero-wait ROM, decode always ready.
        iready = 1'b1; mem_rdy = 1'b1;
        push(32'h0);
        step();
        check("t1_v0", {63'h0, valid}, 64'h1);
        check("t1_req0", {63'h0, req}, 64'h0);
        push(32'h4);
        step();
        check("t1_gap", {31'h0, valid, addr}, {31'h0, 1'b0, 32'h4});
        step();
        check("t1_v1", {63'h0, valid}, 64'h1);
        mem_rdy = 1'b0;
        step();
        check("t1_addr8", {31'h0, req, addr}, {31'h0, 1'b1, 32'h8});

        // Memory stall for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_stall", {31'h0, req, addr}, {31'h0, 1'b1, 32'h8});
            check("t2_noval", {63'h0, valid}, 64'h0);
        end
        mem_rdy = 1'b1;
        push(32'h8);
        #1;
        check("t2_addr", {31'h0, req, addr}, {31'h0, 1'b1, 32'h8});
        step();
        mem_rdy = 1'b0;
        check("t2_valid", {63'h0, valid}, 64'h1);
        step();

        // Decode stalled while an instruction sits in the buffer.
        iready = 1'b0; mem_rdy = 1'b1;
        push(32'hC);
        step();
        mem_rdy = 1'b0;
        hold_code = rom(32'hC);
        hold_pc = 32'hC;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", {code, ipc}, {hold_code, hold_pc});
            check("t3_noreq", {31'h0, valid, req, addr},
                  {31'h0, 1'b1, 1'b0, 32'h10});
            step();
        end
        iready = 1'b1;
        step();
        check("t3_resume", {31'h0, req, addr}, {31'h0, 1'b1, 32'h10});

        // Redirect in the same cycle as memory ready: data discarded.
        redir = 1'b1; redir_pc = 32'h40; mem_rdy = 1'b1;
        step();
        redir = 1'b0; mem_rdy = 1'b0;
        check("t4_flush", {30'h0, valid, req, addr},
              {30'h0, 1'b0, 1'b1, 32'h40});
        mem_rdy = 1'b1;
        push(32'h40);
        step();
        mem_rdy = 1'b0;
        check("t4_pc40", {31'h0, valid, ipc}, {31'h0, 1'b1, 32'h40});
        // Redirect while decode also consumes the buffered instruction.
        redir = 1'b1; redir_pc = 32'h100;
        step();
        redir = 1'b0;
        check("t4_hold_redir", {30'h0, valid, req, addr},
              {30'h0, 1'b0, 1'b1, 32'h100});
        check("t4_nop", {32'h0, code}, {32'h0, NOP});

        // Misaligned target traps until reset.
        redir = 1'b1; redir_pc = 32'h42;
        step();
        redir = 1'b0;
        check("t5_err", {61'h0, err, req, valid}, {61'h0, 1'b1, 1'b0, 1'b0});
        mem_rdy = 1'b1; redir = 1'b1; redir_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_sticky", {61'h0, err, req, valid},
                  {61'h0, 1'b1, 1'b0, 1'b0});
        end
        redir = 1'b0; mem_rdy = 1'b0;
        rst = 1'b1;
        step();
        check("t5_rst_req", {63'h0, req}, 64'h0);
        rst = 1'b0;
        #1;
        check("t5_clear", {30'h0, err, req, addr},
              {30'h0, 1'b0, 1'b1, 32'h0});
        check("sb_empty", 64'(sb_q.size()), 64'h0);

        // Second instance: wrap past the top of the address space.
        rst2 = 1'b0;
        #1;
        check("w_first", {31'h0, req2, addr2}, {31'h0, 1'b1, 32'hFFFF_FFFC});
        rdy2 = 1'b1;
        step();
        rdy2 = 1'b0;
        check("w_inst", {code2, ipc2}, {rom(32'hFFFF_FFFC), 32'hFFFF_FFFC});
        check("w_valid", {63'h0, valid2}, 64'h1);
        step();
        check("w_wrap", {31'h0, req2, addr2}, {31'h0, 1'b1, 32'h0});
        // Reset while the memory returns data: nothing gets buffered.
        rdy2 = 1'b1; rst2 = 1'b1;
        step();
        check("w_rst_req", {62'h0, req2, valid2}, 64'h0);
        rst2 = 1'b0; rdy2 = 1'b0;
        #1;
        check("w_rst_pc", {30'h0, valid2, req2, addr2},
              {30'h0, 1'b0, 1'b1, 32'hFFFF_FFFC});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
